blake2_sched: RTL and testbench

- Sequencer between the byte-serial I/O interface and the BLAKE2s compression core.
- Tracks 64-byte message block assembly from the io stream and maintains the byte counter t.
- Issues init and compress commands to the core and waits for completion.
- After the final block, streams the nn-byte digest back out and gates the host ready signal.

---
 rtl/blake2_pkg.sv | 17 +
 rtl/blake2_t_ctr.sv | 38 +++
 rtl/blake2_sched.sv | 150 +++++++++++++++
 tb/tb_blake2_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blake2_pkg.sv
// Shared types and constants for the BLAKE2s block scheduler.
package blake2_pkg;

   localparam int unsigned BLOCK_BYTES     = 64;
   localparam int unsigned T_W             = 64;
   localparam int unsigned NN_MAX          = 32;
   localparam int unsigned KEY_BLOCK_BYTES = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INIT,
      COMP,
      OUT
   } state_t;

endpackage

// File: rtl/blake2_t_ctr.sv
// Byte counter t and the value presented to the core with each compress command.
module blake2_t_ctr
   import blake2_pkg::*;
#(
   parameter int unsigned T_W = blake2_pkg::T_W
) (
   input  logic           clk,
   input  logic           nreset,
   input  logic           clr,
   input  logic           upd,
   input  logic           last,
   input  logic [5:0]     kk,
   input  logic [T_W-1:0] ll,
   output logic [T_W-1:0] cmp_t
);

   localparam logic [T_W-1:0] KEY_BYTES = T_W'(KEY_BLOCK_BYTES);

   logic [T_W-1:0] t_q;
   logic [T_W-1:0] t_next;

   // The final block reports the true message length (plus the key block), not a running sum.
   always_comb begin
      t_next = last ? (ll + ((kk != '0) ? KEY_BYTES : '0)) : (t_q + KEY_BYTES);
      cmp_t  = upd ? t_next : '0;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         t_q <= '0;
      end else if (clr) begin
         t_q <= '0;
      end else if (upd) begin
         t_q <= t_next;
      end
   end

endmodule

// File: rtl/blake2_sched.sv
// Sequences block assembly, init/compress commands and digest readout for the BLAKE2s core.
module blake2_sched
   import blake2_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = blake2_pkg::BLOCK_BYTES,
   parameter int unsigned T_W         = blake2_pkg::T_W,
   parameter int unsigned NN_MAX      = blake2_pkg::NN_MAX
) (
   input  logic                           clk,
   input  logic                           nreset,
   input  logic [5:0]                     kk_i,
   input  logic [5:0]                     nn_i,
   input  logic [T_W-1:0]                 ll_i,
   input  logic                           data_v_i,
   input  logic [$clog2(BLOCK_BYTES)-1:0] data_idx_i,
   input  logic                           block_first_i,
   input  logic                           block_last_i,
   output logic                           ready_v_o,
   output logic                           cmp_init_o,
   output logic                           cmp_start_o,
   output logic                           cmp_last_o,
   output logic [T_W-1:0]                 cmp_t_o,
   input  logic                           cmp_done_i,
   output logic                           hash_v_o,
   output logic [$clog2(NN_MAX)-1:0]      hash_idx_o,
   output logic                           err_o
);

   localparam int unsigned IDX_W = $clog2(BLOCK_BYTES);
   localparam int unsigned HSH_W = $clog2(NN_MAX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   exp_q, exp_d;
   logic               last_q, last_d;
   logic               start_q, start_d;
   logic               err_q, err_d;
   logic [HSH_W-1:0]   cnt_q, cnt_d;
   logic [5:0]         n_eff;

   assign n_eff = (nn_i > 6'(NN_MAX)) ? 6'(NN_MAX) : nn_i;

   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      last_d      = last_q;
      start_d     = 1'b0;
      err_d       = err_q;
      cnt_d       = cnt_q;
      ready_v_o   = (state_q == IDLE);
      cmp_init_o  = (state_q == INIT);
      cmp_start_o = (state_q == COMP) && start_q;
      cmp_last_o  = last_q;
      hash_v_o    = 1'b0;
      hash_idx_o  = cnt_q;
      err_o       = err_q;

      if (cmp_done_i && (state_q != COMP)) begin
         err_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (data_v_i) begin
               if (data_idx_i == '0) begin
                  state_d = block_first_i ? INIT : LOAD;
                  exp_d   = IDX_W'(1);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         // INIT lasts one cycle but must still accept a byte exactly like LOAD.
         INIT, LOAD: begin
            if (state_q == INIT) begin
               state_d = LOAD;
            end
            if (data_v_i) begin
               if (data_idx_i != exp_q) begin
                  err_d = 1'b1;
               end
               exp_d = data_idx_i + IDX_W'(1);
               if (data_idx_i == LAST_IDX) begin
                  last_d  = block_last_i;
                  start_d = 1'b1;
                  state_d = COMP;
               end
            end
         end
         COMP: begin
            if (data_v_i) begin
               err_d = 1'b1;
            end
            if (cmp_done_i) begin
               cnt_d = '0;
               if (last_q && (n_eff != '0)) begin
                  state_d = OUT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OUT: begin
            if (data_v_i) begin
               err_d = 1'b1;
            end
            hash_v_o = 1'b1;
            cnt_d    = cnt_q + HSH_W'(1);
            if ({1'b0, cnt_q} == (n_eff - 6'd1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         exp_q   <= '0;
         last_q  <= 1'b0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         last_q  <= last_d;
         start_q <= start_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   blake2_t_ctr #(
      .T_W (T_W)
   ) u_t_ctr (
      .clk    (clk),
      .nreset (nreset),
      .clr    (state_q == INIT),
      .upd    (cmp_start_o),
      .last   (last_q),
      .kk     (kk_i),
      .ll     (ll_i),
      .cmp_t  (cmp_t_o)
   );

endmodule

// File: tb/tb_blake2_sched.sv
// Scoreboard bench for blake2_sched: expected compress commands are queued as blocks are sent.
module tb_blake2_sched;

   logic        clk;
   logic        nreset;
   logic [5:0]  kk;
   logic [5:0]  nn;
   logic [63:0] ll;
   logic        data_v;
   logic [5:0]  data_idx;
   logic        block_first;
   logic        block_last;
   logic        ready_v;
   logic        cmp_init;
   logic        cmp_start;
   logic        cmp_last;
   logic [63:0] cmp_t;
   logic        cmp_done;
   logic        hash_v;
   logic [4:0]  hash_idx;
   logic        err;

   typedef struct {
      logic        last;
      logic [63:0] t;
   } cmp_exp_t;

   cmp_exp_t    sb[$];
   logic [63:0] model_t;
   int          init_seen;
   int          checks;
   int          passed;

   blake2_sched #(
      .BLOCK_BYTES (64),
      .T_W         (64),
      .NN_MAX      (32)
   ) dut (
      .clk           (clk),
      .nreset        (nreset),
      .kk_i          (kk),
      .nn_i          (nn),
      .ll_i          (ll),
      .data_v_i      (data_v),
      .data_idx_i    (data_idx),
      .block_first_i (block_first),
      .block_last_i  (block_last),
      .ready_v_o     (ready_v),
      .cmp_init_o    (cmp_init),
      .cmp_start_o   (cmp_start),
      .cmp_last_o    (cmp_last),
      .cmp_t_o       (cmp_t),
      .cmp_done_i    (cmp_done),
      .hash_v_o      (hash_v),
      .hash_idx_o    (hash_idx),
      .err_o         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      nreset      = 1'b0;
      data_v      = 1'b0;
      data_idx    = '0;
      block_first = 1'b0;
      block_last  = 1'b0;
      cmp_done    = 1'b0;
      sb.delete();
      repeat (2) step;
      nreset = 1'b1;
      step;
   endtask

   task automatic push_expected(input bit first, input bit last);
      cmp_exp_t e;
      if (first) model_t = '0;
      e.last = last;
      if (last) e.t = ll + ((kk != 6'd0) ? 64'd64 : 64'd0);
      else      e.t = model_t + 64'd64;
      model_t = e.t;
      sb.push_back(e);
   endtask

   task automatic drive_block(input bit first, input bit last);
      push_expected(first, last);
      for (int i = 0; i < 64; i++) begin
         data_v      = 1'b1;
         data_idx    = 6'(i);
         block_first = first;
         block_last  = last;
         step;
         if (cmp_init) init_seen++;
      end
      data_v = 1'b0;
   endtask

   task automatic wait_start;
      cmp_exp_t e;
      for (int c = 0; c < 20 && !cmp_start; c++) step;
      checks += 2;
      if (cmp_start !== 1'b1) begin
         $display("FAIL start_timeout: cmp_start=%b required 1", cmp_start);
      end else if (sb.size() == 0) begin
         $display("FAIL unexpected_start: cmp_start seen with empty scoreboard");
      end else begin
         e = sb.pop_front();
         if (cmp_last !== e.last)
            $display("FAIL cmp_last: got %b required %b", cmp_last, e.last);
         else passed++;
         if (cmp_t !== e.t)
            $display("FAIL cmp_t: got %0d required %0d", cmp_t, e.t);
         else passed++;
      end
   endtask

   task automatic give_done(input int delay);
      step;
      checks++;
      if (cmp_start !== 1'b0) $display("FAIL start_pulse_width: cmp_start=%b required 0", cmp_start);
      else passed++;
      repeat (delay - 1) step;
      cmp_done = 1'b1;
      step;
      cmp_done = 1'b0;
   endtask

   task automatic collect_out(input int n);
      int seq;
      seq = 0;
      for (int c = 0; c < 60; c++) begin
         if (hash_v) begin
            checks++;
            if (hash_idx !== seq[4:0])
               $display("FAIL hash_idx: got %0d required %0d", hash_idx, seq);
            else passed++;
            seq++;
         end
         if (ready_v) break;
         step;
      end
      checks += 2;
      if (ready_v !== 1'b1) $display("FAIL out_timeout: ready_v=%b required 1", ready_v);
      else passed++;
      if (seq != n) $display("FAIL hash_count: got %0d required %0d", seq, n);
      else passed++;
   endtask

   task automatic check_err(input string name, input logic want);
      checks++;
      if (err !== want) $display("FAIL %s: err=%b required %b", name, err, want);
      else passed++;
   endtask

   task automatic test_reset;
      apply_reset;
      checks += 8;
      if (ready_v !== 1'b1)   $display("FAIL rst_ready: got %b required 1", ready_v);     else passed++;
      if (cmp_init !== 1'b0)  $display("FAIL rst_init: got %b required 0", cmp_init);     else passed++;
      if (cmp_start !== 1'b0) $display("FAIL rst_start: got %b required 0", cmp_start);   else passed++;
      if (cmp_last !== 1'b0)  $display("FAIL rst_last: got %b required 0", cmp_last);     else passed++;
      if (cmp_t !== 64'd0)    $display("FAIL rst_t: got %0d required 0", cmp_t);          else passed++;
      if (hash_v !== 1'b0)    $display("FAIL rst_hash_v: got %b required 0", hash_v);     else passed++;
      if (hash_idx !== 5'd0)  $display("FAIL rst_hash_idx: got %0d required 0", hash_idx); else passed++;
      if (err !== 1'b0)       $display("FAIL rst_err: got %b required 0", err);           else passed++;
   endtask

   task automatic test_single_unkeyed;
      kk = 6'd0; nn = 6'd32; ll = 64'd3;
      init_seen = 0;
      drive_block(1'b1, 1'b1);
      wait_start;
      give_done(2);
      collect_out(32);
      checks += 2;
      if (init_seen != 1) $display("FAIL single_init: got %0d pulses required 1", init_seen); else passed++;
      if (sb.size() != 0) $display("FAIL single_sb: %0d entries left required 0", sb.size()); else passed++;
      check_err("single_err", 1'b0);
   endtask

   task automatic test_keyed_two;
      kk = 6'd16; nn = 6'd40; ll = 64'd64;
      init_seen = 0;
      drive_block(1'b1, 1'b0);
      wait_start;
      give_done(3);
      drive_block(1'b0, 1'b1);
      wait_start;
      give_done(2);
      collect_out(32);
      checks++;
      if (init_seen != 1) $display("FAIL keyed_init: got %0d pulses required 1", init_seen); else passed++;
      check_err("keyed_err", 1'b0);
   endtask

   task automatic test_three_block;
      kk = 6'd0; nn = 6'd20; ll = 64'd150;
      init_seen = 0;
      drive_block(1'b1, 1'b0);
      wait_start;
      give_done(4);
      drive_block(1'b0, 1'b0);
      wait_start;
      give_done(2);
      drive_block(1'b0, 1'b1);
      wait_start;
      give_done(5);
      collect_out(20);
      checks++;
      if (init_seen != 1) $display("FAIL three_init: got %0d pulses required 1", init_seen); else passed++;
      check_err("three_err", 1'b0);
   endtask

   task automatic test_back_to_back;
      kk = 6'd0; nn = 6'd4; ll = 64'd100;
      drive_block(1'b1, 1'b0);
      wait_start;
      give_done(1);
      checks++;
      if (ready_v !== 1'b1) $display("FAIL b2b_ready: got %b required 1", ready_v); else passed++;
      drive_block(1'b0, 1'b1);
      wait_start;
      give_done(1);
      collect_out(4);
      check_err("b2b_err", 1'b0);
   endtask

   task automatic test_nn_zero;
      kk = 6'd8; nn = 6'd0; ll = 64'd0;
      drive_block(1'b1, 1'b1);
      wait_start;
      give_done(2);
      collect_out(0);
      check_err("nn0_err", 1'b0);
   endtask

   task automatic test_errors;
      // Index skip 5 -> 7: err rises and the block still completes.
      apply_reset;
      kk = 6'd0; nn = 6'd0; ll = 64'd10;
      push_expected(1'b1, 1'b1);
      for (int i = 0; i < 64; i++) begin
         if (i == 6) continue;
         data_v = 1'b1; data_idx = 6'(i); block_first = 1'b1; block_last = 1'b1;
         step;
      end
      data_v = 1'b0;
      check_err("skip_err", 1'b1);
      wait_start;
      give_done(2);
      collect_out(0);
      check_err("skip_sticky", 1'b1);
      apply_reset;
      check_err("skip_cleared", 1'b0);

      // Data byte while compressing.
      ll = 64'd5;
      drive_block(1'b1, 1'b1);
      wait_start;
      check_err("comp_pre", 1'b0);
      data_v = 1'b1; data_idx = 6'd0;
      step;
      data_v = 1'b0;
      check_err("comp_data_err", 1'b1);
      cmp_done = 1'b1;
      step;
      cmp_done = 1'b0;
      collect_out(0);
      check_err("comp_sticky", 1'b1);
      apply_reset;
      check_err("comp_cleared", 1'b0);

      // Non-zero first index in IDLE.
      data_v = 1'b1; data_idx = 6'd5; block_first = 1'b1;
      step;
      data_v = 1'b0;
      check_err("idle_idx_err", 1'b1);
      checks += 2;
      if (ready_v !== 1'b1) $display("FAIL idle_idx_ready: got %b required 1", ready_v); else passed++;
      if (cmp_init !== 1'b0) $display("FAIL idle_idx_init: got %b required 0", cmp_init); else passed++;
      repeat (3) step;
      check_err("idle_idx_sticky", 1'b1);
      apply_reset;

      // Stray done outside COMP.
      cmp_done = 1'b1;
      step;
      cmp_done = 1'b0;
      check_err("stray_done_err", 1'b1);
      apply_reset;
   endtask

   task automatic test_reset_mid;
      kk = 6'd0; nn = 6'd4; ll = 64'd7;
      for (int i = 0; i < 30; i++) begin
         data_v = 1'b1; data_idx = 6'(i); block_first = 1'b1; block_last = 1'b0;
         step;
      end
      checks++;
      if (ready_v !== 1'b0) $display("FAIL mid_pre_ready: got %b required 0", ready_v); else passed++;
      #2;
      nreset = 1'b0;
      #1;
      checks += 3;
      if (ready_v !== 1'b1)   $display("FAIL mid_async_ready: got %b required 1", ready_v);   else passed++;
      if (cmp_start !== 1'b0) $display("FAIL mid_async_start: got %b required 0", cmp_start); else passed++;
      if (hash_v !== 1'b0)    $display("FAIL mid_async_hash: got %b required 0", hash_v);     else passed++;
      data_v = 1'b0;
      step;
      nreset = 1'b1;
      step;
      init_seen = 0;
      drive_block(1'b1, 1'b1);
      wait_start;
      give_done(2);
      collect_out(4);
      checks++;
      if (init_seen != 1) $display("FAIL mid_init: got %0d pulses required 1", init_seen); else passed++;
      check_err("mid_err", 1'b0);
   endtask

   initial begin
      checks = 0; passed = 0; init_seen = 0; model_t = '0;
      kk = '0; nn = '0; ll = '0;
      test_reset;
      test_single_unkeyed;
      test_keyed_two;
      test_three_block;
      test_back_to_back;
      test_nn_zero;
      test_errors;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
